inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have port: clock  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: fetch_req  in  1  request next instruction from control path (level; held until instr_valid).
REQ-004 SHALL have port: set_pc  in  1  commit current instruction; advance or redirect PC (one-cycle pulse).
REQ-005 SHALL have port: pc_from_register  in  1  with set_pc, redirect to jump_target instead of pc+1.
REQ-006 SHALL have port: jump_target  in  16  redirect address, sampled when set_pc & pc_from_register.
REQ-007 SHALL have port: rom_rd  out  1  ROM read strobe.
REQ-008 SHALL have port: rom_addr  out  16  ROM word address.
REQ-009 SHALL have port: rom_data  in  16  ROM read data, valid exactly 1 cycle after rom_rd.
REQ-010 SHALL have port: instruction  out  16  current instruction word to control path.
REQ-011 SHALL have port: instr_valid  out  1  instruction holds the word at pc.
REQ-012 SHALL have port: pc  out  16  architectural PC (address of current/next instruction).

Function
REQ-013 SHALL update pc on set_pc: pc_from_register ? jump_target : pc+1, modulo 2^16 (0xFFFF -> 0x0000).
REQ-014 SHALL clear instr_valid the cycle after set_pc; instruction holds its last value until next capture.
REQ-015 SHALL, without prefetch, use FSM IDLE -> ISSUE -> WAIT -> IDLE: IDLE leaves on fetch_req & ~instr_valid; ISSUE drives rom_rd=1, rom_addr=pc; WAIT captures rom_data into instruction, sets instr_valid.
REQ-016 SHALL give non-prefetch latency: fetch_req sampled cycle N -> instr_valid high cycle N+3.
REQ-017 SHALL keep rom_rd low in all states other than issue cycles.
REQ-018 SHALL give set_pc priority over fetch_req in the same cycle; that fetch_req is re-evaluated next cycle against the new pc.
REQ-019 SHALL, if set_pc arrives while a read is in flight, discard the returning rom_data (no capture, instr_valid stays 0).
REQ-020 SHALL ignore fetch_req while instr_valid=1 (no extra reads).
REQ-021 SHALL never assert instr_valid for a word whose address differs from pc.

Reset
REQ-022 SHALL, on reset low, immediately force: pc=0x0000, instruction=0x0000, instr_valid=0, rom_rd=0, rom_addr=0x0000, FSM=IDLE, prefetch queue empty, in-flight tag cleared.
REQ-023 SHALL, on reset mid-read, drop the outstanding ROM response; first read after release is address 0x0000.

Configuration
REQ-024 SHALL compile a 2-entry prefetch queue only when INST_FETCH_PREFETCH_EN is defined.
REQ-025 SHALL, with INST_FETCH_PREFETCH_EN, keep a fetch pointer fpc running ahead of pc, issuing one read per cycle while (queued + in-flight) < 2, each entry storing {addr, data}.
REQ-026 SHALL, with INST_FETCH_PREFETCH_EN, serve fetch_req from a non-empty queue with instr_valid high the next cycle; empty queue waits for the in-flight word.
REQ-027 SHALL, with INST_FETCH_PREFETCH_EN, pop the head on sequential set_pc; on redirect flush queue, discard in-flight data, set fpc=jump_target.
REQ-028 SHALL, without INST_FETCH_PREFETCH_EN, behave exactly per REQ-015..REQ-016 with no queue storage.

Structure
REQ-029 SHALL place fetch FSM state enum, WORD_W=16 and RESET_VECTOR=16'h0000 in shared package cpu_pkg.
REQ-030 SHALL implement the prefetch queue as sub-module fetch_fifo (2-entry, push/pop/flush, full/empty flags), instantiated only under INST_FETCH_PREFETCH_EN.

Verification
REQ-031 SHALL cover: reset release, fetch_req held, ROM[0]=0x2A05 -> rom_rd at addr 0 one cycle, instr_valid and instruction=0x2A05 on cycle 3 (no prefetch).
REQ-032 SHALL cover: pc=0xFFFF, set_pc with pc_from_register=0 -> pc=0x0000, instr_valid=0 next cycle.
REQ-033 SHALL cover: set_pc & pc_from_register with jump_target=0x0040 while read of 0x0005 in flight -> 0x0005 data discarded, next instruction from 0x0040.
REQ-034 SHALL cover: reset asserted during WAIT -> outputs zero immediately; post-release first rom_addr=0x0000.
REQ-035 SHALL cover (prefetch): straight-line ROM[0..3] -> after warm-up each fetch_req yields instr_valid in 1 cycle; addresses 0,1,2,3 in order.
REQ-036 SHALL cover (prefetch): redirect to 0x0100 with queue full -> queue flushed, next rom_addr=0x0100, no stale word delivered.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants for the CPU front end.
// Holds the fetch FSM encoding, word width, reset vector and PC increment helper.
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_ISSUE = 2'd1,
        FETCH_WAIT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } fetch_entry_t;

    // Architectural PC update on commit; the increment wraps naturally at 16 bits.
    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] cur,
                                                  input logic              redirect,
                                                  input logic [WORD_W-1:0] target);
        if (redirect) begin
            return target;
        end else begin
            return cur + 16'd1;
        end
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {addr, data} queue used by the prefetching instruction fetch.
// Flush wins over push/pop; simultaneous push and pop are allowed.
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WORD_W-1:0] push_addr,
    input  logic [WORD_W-1:0] push_data,
    output logic [WORD_W-1:0] head_addr,
    output logic [WORD_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    fetch_entry_t mem_r [2];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    logic [1:0]   count_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign full      = (count_r == 2'd2);
    assign empty     = (count_r == 2'd0);
    assign count     = count_r;
    assign head_addr = mem_r[rd_ptr_r].addr;
    assign head_data = mem_r[rd_ptr_r].data;
    assign push_ok_s = push & (~full | pop);
    assign pop_ok_s  = pop & ~empty;

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= '{addr: push_addr, data: push_data};
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: tracks the architectural PC and reads words from ROM.
// Define INST_FETCH_PREFETCH_EN to build the 2-entry prefetch variant.
module inst_fetch
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              set_pc,
    input  logic              pc_from_register,
    input  logic [WORD_W-1:0] jump_target,
    output logic              rom_rd,
    output logic [WORD_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [WORD_W-1:0] instruction,
    output logic              instr_valid,
    output logic [WORD_W-1:0] pc
);

    logic [WORD_W-1:0] pc_r, pc_s;
    logic [WORD_W-1:0] instruction_r, instruction_s;
    logic              instr_valid_r, instr_valid_s;
    logic              rom_rd_r, rom_rd_s;
    logic [WORD_W-1:0] rom_addr_r, rom_addr_s;

    assign pc          = pc_r;
    assign instruction = instruction_r;
    assign instr_valid = instr_valid_r;
    assign rom_rd      = rom_rd_r;
    assign rom_addr    = rom_addr_r;

    // Registered outputs shared by both build variants.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_r          <= RESET_VECTOR;
            instruction_r <= 16'h0000;
            instr_valid_r <= 1'b0;
            rom_rd_r      <= 1'b0;
            rom_addr_r    <= 16'h0000;
        end else begin
            pc_r          <= pc_s;
            instruction_r <= instruction_s;
            instr_valid_r <= instr_valid_s;
            rom_rd_r      <= rom_rd_s;
            rom_addr_r    <= rom_addr_s;
        end
    end

`ifdef INST_FETCH_PREFETCH_EN

    logic [WORD_W-1:0] fpc_r, fpc_s, fpc_base_s;
    logic              ret_r, ret_s;
    logic [WORD_W-1:0] ret_addr_r, ret_addr_s;
    logic [WORD_W-1:0] head_addr_s, head_data_s;
    logic              full_s, empty_s;
    logic [1:0]        fifo_count_s, count_next_s, occ_s;
    logic              push_s, pop_s, flush_s, seq_flush_s, serve_s;

    fetch_fifo u_fetch_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (flush_s),
        .push_addr (ret_addr_r),
        .push_data (rom_data),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (fifo_count_s)
    );

    // Prefetch bookkeeping: fetch pointer and the tag of the word returning this cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fpc_r      <= RESET_VECTOR;
            ret_r      <= 1'b0;
            ret_addr_r <= 16'h0000;
        end else begin
            fpc_r      <= fpc_s;
            ret_r      <= ret_s;
            ret_addr_r <= ret_addr_s;
        end
    end

    // Queue control, PC update, delivery and read issue.
    always_comb begin
        pc_s          = pc_r;
        instruction_s = instruction_r;
        instr_valid_s = instr_valid_r;
        rom_rd_s      = 1'b0;
        rom_addr_s    = rom_addr_r;
        fpc_s         = fpc_r;
        // A sequential commit whose head does not match pc restarts the stream at pc+1.
        seq_flush_s   = set_pc & ~pc_from_register & (empty_s | (head_addr_s != pc_r));
        flush_s       = (set_pc & pc_from_register) | seq_flush_s;
        pop_s         = set_pc & ~flush_s;
        push_s        = ret_r & ~flush_s;
        ret_s         = rom_rd_r & ~flush_s;
        serve_s       = fetch_req & ~instr_valid_r & ~set_pc & ~empty_s & (head_addr_s == pc_r);
        if (rom_rd_r) begin
            ret_addr_s = rom_addr_r;
        end else begin
            ret_addr_s = ret_addr_r;
        end
        if (flush_s) begin
            count_next_s = 2'd0;
        end else begin
            count_next_s = fifo_count_s + {1'b0, push_s} - {1'b0, pop_s};
        end
        occ_s = count_next_s + {1'b0, ret_s};
        if (set_pc) begin
            pc_s          = next_pc(pc_r, pc_from_register, jump_target);
            instr_valid_s = 1'b0;
        end else if (serve_s) begin
            instruction_s = head_data_s;
            instr_valid_s = 1'b1;
        end else begin
            pc_s = pc_r;
        end
        if (flush_s) begin
            fpc_base_s = pc_s;
        end else begin
            fpc_base_s = fpc_r;
        end
        if ((occ_s < 2'd2) && !(full_s && !pop_s && !flush_s)) begin
            rom_rd_s   = 1'b1;
            rom_addr_s = fpc_base_s;
            fpc_s      = fpc_base_s + 16'd1;
        end else begin
            fpc_s = fpc_base_s;
        end
    end

`else

    fetch_state_t state_r, state_s;

    // Fetch FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, read issue and capture; a commit abandons any read in progress.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        instruction_s = instruction_r;
        instr_valid_s = instr_valid_r;
        rom_rd_s      = 1'b0;
        rom_addr_s    = rom_addr_r;
        case (state_r)
            FETCH_IDLE: begin
                if (set_pc) begin
                    state_s = FETCH_IDLE;
                end else if (fetch_req && !instr_valid_r) begin
                    state_s    = FETCH_ISSUE;
                    rom_rd_s   = 1'b1;
                    rom_addr_s = pc_r;
                end else begin
                    state_s = FETCH_IDLE;
                end
            end
            FETCH_ISSUE: begin
                if (set_pc) begin
                    state_s = FETCH_IDLE;
                end else begin
                    state_s = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                state_s = FETCH_IDLE;
                if (!set_pc) begin
                    instruction_s = rom_data;
                    instr_valid_s = 1'b1;
                end else begin
                    instr_valid_s = 1'b0;
                end
            end
            default: begin
                state_s = FETCH_IDLE;
            end
        endcase
        if (set_pc) begin
            pc_s          = next_pc(pc_r, pc_from_register, jump_target);
            instr_valid_s = 1'b0;
        end else begin
            pc_s = pc_r;
        end
    end

`endif

endmodule
